// File: rtl/spi_pkg.sv
// spi_pkg: shared types, constants and lane mapping for the SPI master read path
package spi_pkg;
  typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} spi_endian_e;
  localparam int DISCARD_CNT_W = 16;
  function automatic int lane_pos(input int idx, input int pack, input int endian);
    return endian == int'(MSB_FIRST) ? pack - 1 - idx : idx;
  endfunction
endpackage

// File: rtl/spi_rd_fifo.sv
// spi_rd_fifo: show-ahead FIFO; head reads zero while empty so idle outputs stay clean
module spi_rd_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign do_push = push && !full && !clr;
  assign do_pop = pop && level != '0;
  assign dout = level != '0 ? mem[rp] : '0;
  always_ff @(posedge rd_clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge rd_clk or negedge rd_rst_n)
    if (!rd_rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/spi_rd_pack.sv
// spi_rd_pack: packs deserialised read words into wide beats behind a small FIFO
module spi_rd_pack import spi_pkg::*; #(
  parameter int IN_W = 8,
  parameter int PACK = 4,
  parameter int DEPTH = 4,
  parameter int ENDIAN = 0
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst_n,
  input  logic                         flush,
  input  logic                         discard,
  input  logic                         in_vld,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_last,
  output logic                         out_vld,
  input  logic                         out_ready,
  output logic [IN_W*PACK-1:0]         out_data,
  output logic [PACK-1:0]              out_keep,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [DISCARD_CNT_W-1:0]     discard_cnt
);
  localparam int IW = PACK > 1 ? $clog2(PACK) : 1;
  localparam int FW = 1 + PACK + IN_W * PACK;
  logic full, acc, pack_en, push;
  logic [IW-1:0] idx;
  logic [IN_W*PACK-1:0] pk_data, nxt_data;
  logic [PACK-1:0] pk_keep, nxt_keep;
  logic [FW-1:0] head;
  assign in_ready = !flush && (discard || !full);
  assign acc = in_vld && in_ready;
  assign pack_en = acc && !discard;
  assign push = pack_en && (in_last || int'(idx) == PACK - 1);
  // nxt_* is the beat including the current word; it is what gets pushed
  always_comb begin
    nxt_data = pk_data;
    nxt_keep = pk_keep;
    for (int j = 0; j < PACK; j++)
      if (j == lane_pos(int'(idx), PACK, ENDIAN)) begin
        nxt_data[j*IN_W +: IN_W] = in_data;
        nxt_keep[j] = 1'b1;
      end
  end
  always_ff @(posedge rd_clk or negedge rd_rst_n)
    if (!rd_rst_n) begin
      idx <= '0;
      pk_data <= '0;
      pk_keep <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      idx <= '0;
      pk_data <= '0;
      pk_keep <= '0;
      discard_cnt <= '0;
    end else begin
      if (pack_en) begin
        idx <= push ? '0 : idx + 1'b1;
        pk_data <= push ? '0 : nxt_data;
        pk_keep <= push ? '0 : nxt_keep;
      end
      if (acc && discard && discard_cnt != '1) discard_cnt <= discard_cnt + 1'b1;
    end
  spi_rd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .clr      (flush),
    .push     (push),
    .din      ({in_last, nxt_keep, nxt_data}),
    .pop      (out_ready),
    .dout     (head),
    .full     (full),
    .level    (level)
  );
  assign out_vld = level != '0;
  assign {out_last, out_keep, out_data} = head;
endmodule

// File: tb/tb_spi_rd_pack.sv
// tb_spi_rd_pack: directed table, corner sequences and random traffic against a word-list model
module tb_spi_rd_pack;
  logic rd_clk = 0, rd_rst_n = 0, flush = 0, discard = 0, in_vld = 0, in_last = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic rdy0, rdy1, vld0, vld1, last0, last1;
  logic [31:0] d0, d1;
  logic [3:0] k0, k1;
  logic [2:0] lvl0, lvl1;
  logic [15:0] cnt0, cnt1;
  int vec = 0, miss = 0;

  always #5 rd_clk = ~rd_clk;

  spi_rd_pack #(.IN_W(8), .PACK(4), .DEPTH(4), .ENDIAN(0)) u0 (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .flush(flush), .discard(discard), .in_vld(in_vld),
    .in_ready(rdy0), .in_data(in_data), .in_last(in_last), .out_vld(vld0), .out_ready(out_ready),
    .out_data(d0), .out_keep(k0), .out_last(last0), .level(lvl0), .discard_cnt(cnt0));
  spi_rd_pack #(.IN_W(8), .PACK(4), .DEPTH(4), .ENDIAN(1)) u1 (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .flush(flush), .discard(discard), .in_vld(in_vld),
    .in_ready(rdy1), .in_data(in_data), .in_last(in_last), .out_vld(vld1), .out_ready(out_ready),
    .out_data(d1), .out_keep(k1), .out_last(last1), .level(lvl1), .discard_cnt(cnt1));

  typedef struct {
    logic [31:0] d0, d1;
    logic [3:0] k0, k1;
    logic last;
  } beat_t;
  beat_t q[$];
  logic [7:0] words[$];
  int m_cnt = 0;

  typedef struct {
    logic v; logic [7:0] d; logic l, dis, r;
    logic ev; logic [31:0] e0, e1; logic [3:0] ek0, ek1; logic el; logic [15:0] ec;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_clear();
    q.delete();
    words.delete();
    m_cnt = 0;
  endfunction

  task automatic model_check();
    logic mr = !flush && (discard || q.size() < 4);
    chk("in_ready", rdy0, mr);
    chk("in_ready_e1", rdy1, mr);
    chk("out_vld", vld0, q.size() != 0);
    chk("out_vld_e1", vld1, q.size() != 0);
    chk("level", lvl0, q.size());
    chk("level_e1", lvl1, q.size());
    chk("discard_cnt", cnt0, m_cnt);
    if (q.size() != 0) begin
      chk("out_data", d0, q[0].d0);
      chk("out_keep", k0, q[0].k0);
      chk("out_last", last0, q[0].last);
      chk("out_data_e1", d1, q[0].d1);
      chk("out_keep_e1", k1, q[0].k1);
      chk("out_last_e1", last1, q[0].last);
    end
  endtask

  // Words collect in a list; a beat is built from the whole list when it closes
  task automatic model_step();
    logic mr = !flush && (discard || q.size() < 4);
    beat_t b;
    if (flush) begin
      m_clear();
      return;
    end
    if (out_ready && q.size() != 0) q.delete(0);
    if (in_vld && mr) begin
      if (discard) begin
        if (m_cnt < 65535) m_cnt++;
      end else begin
        words.push_back(in_data);
        if (words.size() == 4 || in_last) begin
          b = '{default: 0};
          b.last = in_last;
          foreach (words[i]) begin
            b.d0[i*8 +: 8] = words[i];
            b.k0[i] = 1'b1;
            b.d1[(3-i)*8 +: 8] = words[i];
            b.k1[3-i] = 1'b1;
          end
          q.push_back(b);
          words.delete();
        end
      end
    end
  endtask

  task automatic set_in(input logic v, input logic [7:0] d, input logic l, input logic dis,
                        input logic r, input logic f);
    @(negedge rd_clk);
    in_vld = v; in_data = d; in_last = l; discard = dis; out_ready = r; flush = f;
    #1;
  endtask

  task automatic cyc();
    model_check();
    model_step();
    @(posedge rd_clk);
    #1;
  endtask

  function automatic logic [31:0] bp_beat(input int b);
    logic [31:0] x;
    for (int i = 0; i < 4; i++) x[i*8 +: 8] = 8'(4 * b + i);
    return x;
  endfunction

  task automatic build_state();
    for (int i = 0; i < 14; i++) begin
      set_in(1, 8'(8'h40 + i), 0, 0, 0, 0);
      cyc();
    end
    set_in(1, 8'h99, 0, 1, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int acc, n, b;
    logic took;
    tbl[0]  = '{1, 8'h11, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 8'h22, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 8'h33, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 8'h44, 1, 0, 1, 1, 32'h44332211, 32'h11223344, 4'hF, 4'hF, 1, 0};
    tbl[4]  = '{1, 8'hA1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 8'hA2, 1, 0, 1, 1, 32'h0000A2A1, 32'hA1A20000, 4'h3, 4'hC, 1, 0};
    tbl[6]  = '{1, 8'hEE, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{1, 8'hEF, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2};
    tbl[8]  = '{1, 8'hF0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3};
    tbl[9]  = '{1, 8'h01, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3};
    tbl[10] = '{1, 8'h02, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3};
    tbl[11] = '{1, 8'h03, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3};
    tbl[12] = '{1, 8'h04, 0, 0, 1, 1, 32'h04030201, 32'h01020304, 4'hF, 4'hF, 0, 3};
    tbl[13] = '{0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3};

    #1;
    chk("rst_out_vld", vld0, 0);
    chk("rst_out_data", d0, 0);
    chk("rst_out_keep", k0, 0);
    chk("rst_level", lvl0, 0);
    chk("rst_discard_cnt", cnt0, 0);
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    rd_rst_n = 1;

    foreach (tbl[i]) begin
      set_in(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].dis, tbl[i].r, 0);
      cyc();
      chk($sformatf("tbl%0d_vld", i), vld0, tbl[i].ev);
      chk($sformatf("tbl%0d_cnt", i), cnt0, tbl[i].ec);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_data", i), d0, tbl[i].e0);
        chk($sformatf("tbl%0d_keep", i), k0, tbl[i].ek0);
        chk($sformatf("tbl%0d_last", i), last0, tbl[i].el);
        chk($sformatf("tbl%0d_data_e1", i), d1, tbl[i].e1);
        chk($sformatf("tbl%0d_keep_e1", i), k1, tbl[i].ek1);
      end
    end

    acc = 0; n = 0;
    while (acc < 16 && n < 40) begin
      took = q.size() < 4;
      set_in(1, 8'(acc), 0, 0, 0, 0);
      cyc();
      if (took) acc++;
      n++;
    end
    chk("bp_accept16", acc, 16);
    set_in(1, 8'(acc), 0, 0, 0, 0);
    chk("bp_level_full", lvl0, 4);
    chk("bp_in_ready_low", rdy0, 0);
    b = 0; n = 0;
    while (b < 5 && n < 40) begin
      took = acc < 20 && q.size() < 4;
      set_in(acc < 20, 8'(acc), 0, 0, 1, 0);
      if (vld0) begin
        chk($sformatf("bp_beat%0d", b), d0, bp_beat(b));
        b++;
      end
      cyc();
      if (took) acc++;
      n++;
    end
    chk("bp_beats5", b, 5);

    n = 0;
    while (q.size() != 0 && n < 10) begin
      set_in(0, 0, 0, 0, 1, 0);
      cyc();
      n++;
    end
    build_state();
    chk("pre_flush_level", lvl0, 3);
    set_in(1, 8'h77, 0, 0, 0, 1);
    chk("flush_in_ready", rdy0, 0);
    cyc();
    chk("flush_out_vld", vld0, 0);
    chk("flush_level", lvl0, 0);
    chk("flush_cnt", cnt0, 0);
    chk("flush_data", d0, 0);
    set_in(1, 8'h5A, 1, 0, 0, 0);
    cyc();
    chk("post_flush_data", d0, 32'h0000005A);
    chk("post_flush_keep", k0, 4'h1);
    chk("post_flush_data_e1", d1, 32'h5A000000);

    set_in(1, 0, 0, 0, 0, 1);
    cyc();
    build_state();
    @(negedge rd_clk);
    #2 rd_rst_n = 0;
    #1;
    chk("arst_out_vld", vld0, 0);
    chk("arst_level", lvl0, 0);
    chk("arst_data", d0, 0);
    chk("arst_keep", k0, 0);
    chk("arst_last", last0, 0);
    chk("arst_cnt", cnt0, 0);
    chk("arst_out_vld_e1", vld1, 0);
    chk("arst_data_e1", d1, 0);
    m_clear();
    @(negedge rd_clk);
    rd_rst_n = 1;

    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
      cyc();
    end
    set_in(0, 0, 0, 0, 1, 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/spi_rd_pack.md
# spi_rd_pack

Parametrised read-side output stage for the SPI master. It sits in the `rd_clk` domain between the deserialiser read port and the user read interface, and replaces the single-register `rd_vld`/`rd_data` holding stage. It packs `PACK` deserialised words into one wide output beat, drops words while `discard` is high (dummy/address phase), and buffers `DEPTH` beats behind a valid/ready handshake. It also marks partial final beats with a lane-keep mask and a last flag.

## Interface

Parameters:
- `IN_W`, 8, width of one deserialised word (SSIZE*CSNUM).
- `PACK`, 4, words per output beat; ≥1.
- `DEPTH`, 4, output FIFO entries; power of 2, ≥2.
- `ENDIAN`, 0, lane order: 0 puts the first word in the LSB lane, 1 puts the first word in the MSB lane.

Ports (clock and reset first):
- `rd_clk`  in  1  Clock.
- `rd_rst_n`  in  1  Reset, asynchronous, active-low.
- `flush`  in  1  Synchronous clear of packer, FIFO and counters (driven from rst_fifo).
- `discard`  in  1  Level; accepted input words are dropped.
- `in_vld`  in  1  Input word valid.
- `in_ready`  out  1  Input word accepted when `in_vld & in_ready`.
- `in_data`  in  IN_W  Input word.
- `in_last`  in  1  Input word is the last of the transfer.
- `out_vld`  out  1  Output beat valid.
- `out_ready`  in  1  Output beat consumed when `out_vld & out_ready`.
- `out_data`  out  IN_W*PACK  Output beat.
- `out_keep`  out  PACK  `out_keep[j]` set means `out_data[j*IN_W +: IN_W]` holds a real word.
- `out_last`  out  1  Beat closes the transfer.
- `level`  out  $clog2(DEPTH+1)  Number of FIFO entries occupied.
- `discard_cnt`  out  16  Words dropped since the last reset or flush; saturates at 16'hFFFF.

## Operation

**Reset values:** `out_vld`, `out_data`, `out_keep`, `out_last`, `level`, `discard_cnt` are 0. The packer is empty and the lane index is 0.

**in_ready:** `in_ready = !flush & (discard | !full)`. `full` is registered (`level==DEPTH`). There is no combinational path from `out_ready`.

**Discard:** applies when an input word is accepted with `discard=1`.
- The word is dropped and the packer is untouched.
- `discard_cnt` increments.
- `in_last` is ignored.

**Pack:** applies when an input word is accepted with `discard=0`.
- The word is written to lane `idx`, and `idx` increments.
- ENDIAN=0: lane `idx` maps to bit position `idx`.
- ENDIAN=1: lane `idx` maps to bit position `PACK-1-idx`.
- `out_keep` is indexed by bit position.

**Push:** triggered when the accepted word fills lane PACK-1, or carries `in_last`.
- The beat (data, keep, last = `in_last`) is pushed into the FIFO in the same cycle.
- The packer clears and `idx` returns to 0.
- Unused lanes are zero and their keep bits are 0.

**FIFO:** show-ahead.
- `out_*` reflect the head entry; `out_vld = level!=0`.
- A pop happens on `out_vld & out_ready`.
- Push and pop in the same cycle leave `level` unchanged.
- A push is never attempted when full, because `in_ready` is low.

**Flush:** highest priority.
- Clears the packer, `idx`, FIFO, `level` and `discard_cnt` in one cycle.
- `in_ready` is 0 during the flush cycle.
- Outputs read 0 or invalid on the next cycle.

**Reset mid-transfer:** immediately returns everything to the reset values, including any partial packer content, which is lost.

**PACK=1:** every accepted word pushes, `out_keep` is 1, and `out_last` is a copy of `in_last`.

## Timing

- **Latency:** a word that completes a beat at edge n, with the FIFO empty, gives `out_vld=1` with that beat after edge n.
- **Throughput:** 1 input word per cycle. Output is sustained at 1 beat per PACK words.
- **out_ready:** `out_data`/`out_keep`/`out_last` are stable while `out_vld=1` and `out_ready=0`.
- **Full:** after the pop edge `level` drops, `full` deasserts, and `in_ready` rises in the following cycle.
- **discard:** sampled per accepted word. A toggle mid-packet does not reset `idx`.

## Structure

- **Shared package `spi_pkg`:**
  - `spi_endian_e` (LSB_FIRST=0, MSB_FIRST=1).
  - The `DISCARD_CNT_W=16` constant.
  - The lane-position function `lane_pos(idx, PACK, ENDIAN)`.
- **Sub-module `spi_rd_fifo`:**
  - Synchronous show-ahead FIFO parameterised by width and `DEPTH`, holding {last, keep, data}.
  - Ports: push/pop, full, level, sync clear.
- **Top level:** holds the packer, lane index, discard counter and `in_ready` logic.

## Test plan

All scenarios use IN_W=8, PACK=4, DEPTH=4.

1. ENDIAN=0: push 11,22,33,44 with `in_last` on 44 and `out_ready=1` → one cycle later `out_data=32'h44332211`, `out_keep=4'hF`, `out_last=1`.
2. ENDIAN=1: same stimulus → `out_data=32'h11223344`, `out_keep=4'hF`.
3. Partial beat, ENDIAN=0: push A1, A2 (last on A2) → `out_data=32'h0000A2A1`, `out_keep=4'b0011`, `out_last=1`. With ENDIAN=1 → `32'hA1A20000`, `out_keep=4'b1100`.
4. Backpressure: hold `out_ready=0` and offer 20 words (values 0..19).
   - After 16 accepted words: `level=4`, `in_ready=0`.
   - On release: 5 beats in order (00..03 … 10..13), no loss or duplication.
5. Discard: 3 words with `discard=1`, then 4 words 01..04 with `discard=0` → `discard_cnt=3`, single beat `32'h04030201`.
6. Mid-operation clears:
   - Flush with 2 words in the packer and 3 beats in the FIFO → next cycle `out_vld=0`, `level=0`, `discard_cnt=0`. The next word lands in lane 0.
   - The same state with `rd_rst_n` pulsed asynchronously gives all outputs 0 immediately.
